// File: rtl/edge_event_if.sv
// -----------------------------------------------------------------------------
// edge_event_if
// Bundles the per-row detect input and the event output handshake of
// edge_event_reporter.
//   detect_valid / detect : per-row edge flags from the detector pipeline
//   event_valid / event_ready / event_row / event_time : event FIFO head
//   overflow              : sticky "an event was lost" flag
//   event_count / drop_count : statistics, present only when the
//                              EDGE_EVENT_STATS_EN macro is defined
// Modports: master = producer/consumer side (testbench, host),
//           slave  = edge_event_reporter itself.
// -----------------------------------------------------------------------------
interface edge_event_if #(
    parameter int PIXEL_HEIGHT = 5,
    parameter int TS_WIDTH     = 16,
    parameter int ROW_W        = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1
);
    logic                    detect_valid;
    logic [PIXEL_HEIGHT-1:0] detect;
    logic                    event_valid;
    logic                    event_ready;
    logic [ROW_W-1:0]        event_row;
    logic [TS_WIDTH-1:0]     event_time;
    logic                    overflow;
`ifdef EDGE_EVENT_STATS_EN
    logic [15:0]             event_count;
    logic [7:0]              drop_count;

    modport master (
        output detect_valid, detect, event_ready,
        input  event_valid, event_row, event_time, overflow,
        input  event_count, drop_count
    );
    modport slave (
        input  detect_valid, detect, event_ready,
        output event_valid, event_row, event_time, overflow,
        output event_count, drop_count
    );
`else
    modport master (
        output detect_valid, detect, event_ready,
        input  event_valid, event_row, event_time, overflow
    );
    modport slave (
        input  detect_valid, detect, event_ready,
        output event_valid, event_row, event_time, overflow
    );
`endif
endinterface

// File: rtl/edge_event_reporter.sv
// -----------------------------------------------------------------------------
// edge_event_reporter
// Turns 0->1 transitions of per-row detect flags into timestamped events.
// Each rise is parked in a per-row pending slot, the lowest pending row is
// moved into the event FIFO once per cycle, and a per-row hold-off window
// swallows further rises after an event has been queued.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   ev      : edge_event_if.slave (detect input, event handshake, overflow)
// Optional feature macro: EDGE_EVENT_STATS_EN adds saturating event_count and
// drop_count outputs on the interface.
// -----------------------------------------------------------------------------
module edge_event_reporter #(
    parameter int PIXEL_HEIGHT = 5,
    parameter int HOLDOFF      = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int TS_WIDTH     = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    edge_event_if.slave ev
);
    localparam int ROW_W   = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1;
    localparam int HOLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ROW_W + TS_WIDTH;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [TS_WIDTH-1:0]     ts_q, ts_d;
    logic [PIXEL_HEIGHT-1:0] prev_q, prev_d;
    logic [PIXEL_HEIGHT-1:0] pending_q, pending_d;
    logic [TS_WIDTH-1:0]     pts_q [PIXEL_HEIGHT];
    logic [TS_WIDTH-1:0]     pts_d [PIXEL_HEIGHT];
    logic [HOLD_W-1:0]       hold_q [PIXEL_HEIGHT];
    logic [HOLD_W-1:0]       hold_d [PIXEL_HEIGHT];
    logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        mem_cnt_q, mem_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [ROW_W-1:0]        out_row_q, out_row_d;
    logic [TS_WIDTH-1:0]     out_time_q, out_time_d;
    logic                    overflow_q, overflow_d;

    logic [PIXEL_HEIGHT-1:0] rise_s, clear_s, drop_s;
    logic                    full_s, found_s, push_s, pop_s, load_s;
    logic [ROW_W-1:0]        push_row_s;
    logic [TS_WIDTH-1:0]     push_ts_s;

    // Rise detection, lowest-row selection and per-row pending/hold-off rules
    always_comb begin
        ts_d   = ts_q + TS_WIDTH'(1);
        prev_d = ev.detect_valid ? ev.detect : prev_q;
        rise_s = {PIXEL_HEIGHT{ev.detect_valid}} & ev.detect & ~prev_q;
        // Occupancy counts the output stage too, so "full" is FIFO_DEPTH events
        full_s = ((mem_cnt_q + CNT_W'(out_valid_q)) == FULL_CNT);

        found_s    = 1'b0;
        push_row_s = '0;
        push_ts_s  = '0;
        for (int i = 0; i < PIXEL_HEIGHT; i++) begin
            if (pending_q[i] && !found_s) begin
                found_s    = 1'b1;
                push_row_s = ROW_W'(i);
                push_ts_s  = pts_q[i];
            end else begin
                found_s    = found_s;
            end
        end
        push_s = found_s & ~full_s;

        overflow_d = overflow_q;
        for (int i = 0; i < PIXEL_HEIGHT; i++) begin
            clear_s[i]   = push_s && (push_row_s == ROW_W'(i));
            pending_d[i] = pending_q[i] & ~clear_s[i];
            pts_d[i]     = pts_q[i];
            drop_s[i]    = 1'b0;
            if (clear_s[i]) begin
                hold_d[i] = HOLD_LOAD;
            end else if (hold_q[i] != '0) begin
                hold_d[i] = hold_q[i] - HOLD_W'(1);
            end else begin
                hold_d[i] = hold_q[i];
            end
            // Rises inside the hold-off window are silently swallowed
            if (rise_s[i] && (hold_q[i] == '0)) begin
                if (pending_q[i] && !clear_s[i]) begin
                    drop_s[i] = 1'b1;
                end else if (clear_s[i] && (HOLDOFF > 0)) begin
                    // Coincides with the hold-off load: counts as a rise in hold-off
                    drop_s[i] = 1'b0;
                end else begin
                    pending_d[i] = 1'b1;
                    pts_d[i]     = ts_q;
                end
            end else begin
                drop_s[i] = 1'b0;
            end
        end
        overflow_d = overflow_q | (|drop_s);
    end

    // Event FIFO: storage ring plus a registered head stage feeding the outputs
    always_comb begin
        mem_d  = mem_q;
        pop_s  = out_valid_q & ev.event_ready;
        load_s = (!out_valid_q || pop_s) && (mem_cnt_q != '0);
        if (push_s) begin
            mem_d[wr_ptr_q] = {push_row_s, push_ts_s};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (load_s) begin
            rd_ptr_d                 = rd_ptr_q + PTR_W'(1);
            out_valid_d              = 1'b1;
            {out_row_d, out_time_d}  = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d                 = rd_ptr_q;
            out_valid_d              = out_valid_q & ~pop_s;
            out_row_d                = out_row_q;
            out_time_d               = out_time_q;
        end
        mem_cnt_d = mem_cnt_q + CNT_W'(push_s) - CNT_W'(load_s);
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q        <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            for (int i = 0; i < PIXEL_HEIGHT; i++) begin
                pts_q[i]  <= '0;
                hold_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_time_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            pts_q       <= pts_d;
            hold_q      <= hold_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_time_q  <= out_time_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ev.event_valid = out_valid_q;
    assign ev.event_row   = out_row_q;
    assign ev.event_time  = out_time_q;
    assign ev.overflow    = overflow_q;

`ifdef EDGE_EVENT_STATS_EN
    logic [15:0] event_count_q, event_count_d;
    logic [7:0]  drop_count_q, drop_count_d;
    logic [8:0]  drop_num_s, drop_sum_s;

    // Saturating statistics; several rows may drop in the same cycle
    always_comb begin
        drop_num_s = 9'd0;
        for (int i = 0; i < PIXEL_HEIGHT; i++) begin
            drop_num_s = drop_num_s + 9'(drop_s[i]);
        end
        drop_sum_s   = {1'b0, drop_count_q} + drop_num_s;
        drop_count_d = (drop_sum_s > 9'h0FF) ? 8'hFF : drop_sum_s[7:0];
        if (pop_s && (event_count_q != 16'hFFFF)) begin
            event_count_d = event_count_q + 16'd1;
        end else begin
            event_count_d = event_count_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            event_count_q <= 16'd0;
            drop_count_q  <= 8'd0;
        end else begin
            event_count_q <= event_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign ev.event_count = event_count_q;
    assign ev.drop_count  = drop_count_q;
`endif
endmodule

// File: tb/tb_edge_event_reporter.sv
// -----------------------------------------------------------------------------
// tb_edge_event_reporter
// Directed scenarios plus randomized traffic. A reference model tracks the
// per-row rules (pending slot, hold-off window, lost events) and keeps the
// event FIFO as a queue of {row, time, push cycle}; every event it queues is
// also pushed onto a scoreboard that a negedge monitor pops on each DUT
// handshake.
// -----------------------------------------------------------------------------
module tb_edge_event_reporter;
    localparam int PH  = 5;
    localparam int HO  = 8;
    localparam int FD  = 4;
    localparam int TSW = 16;

    logic clock;
    logic reset_n;

    edge_event_if #(.PIXEL_HEIGHT(PH), .TS_WIDTH(TSW)) ev ();

    edge_event_reporter #(
        .PIXEL_HEIGHT(PH), .HOLDOFF(HO), .FIFO_DEPTH(FD), .TS_WIDTH(TSW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ev      (ev.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int row; int tm; int pe; } ent_t;

    ent_t        mq[$];      // model of everything not yet consumed
    ent_t        exp_q[$];   // scoreboard of expected events, in order
    bit [PH-1:0] m_prev, m_pend;
    int          m_pts [PH];
    int          m_hold [PH];
    bit          m_ovf, m_valid, run;
    int          m_ts, m_edge, m_pops, m_drops;
    int          total, bad, dut_pops;
    int          last_time [2];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_prev = '0;
        m_pend = '0;
        for (int i = 0; i < PH; i++) begin
            m_pts[i]  = 0;
            m_hold[i] = 0;
        end
        m_ovf = 1'b0; m_valid = 1'b0;
        m_ts = 0; m_edge = 0; m_pops = 0; m_drops = 0;
        run = 1'b1;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit          full;
        int          sel;
        bit [PH-1:0] rise, pend0;
        ent_t        e;
        m_edge++;
        full = (mq.size() == FD);
        if (m_valid && ev.event_ready) begin
            e = mq.pop_front();
            m_pops++;
        end
        rise  = ev.detect_valid ? (ev.detect & ~m_prev) : '0;
        pend0 = m_pend;
        sel   = -1;
        if (!full) begin
            for (int i = PH - 1; i >= 0; i--) if (pend0[i]) sel = i;
        end
        if (sel >= 0) begin
            e.row = sel; e.tm = m_pts[sel]; e.pe = m_edge;
            mq.push_back(e);
            exp_q.push_back(e);
            m_pend[sel] = 1'b0;
        end
        for (int i = 0; i < PH; i++) begin
            if (rise[i] && m_hold[i] == 0) begin
                if (pend0[i] && i != sel) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else if (i == sel && HO > 0) begin
                end else begin
                    m_pend[i] = 1'b1;
                    m_pts[i]  = m_ts;
                end
            end
        end
        for (int i = 0; i < PH; i++) begin
            if (i == sel) m_hold[i] = HO;
            else if (m_hold[i] > 0) m_hold[i]--;
        end
        if (ev.detect_valid) m_prev = ev.detect;
        m_ts = (m_ts + 1) % 65536;
        // An event becomes visible one edge after it enters the FIFO
        m_valid = (mq.size() > 0) && (mq[0].pe < m_edge);
    endtask

    task automatic cyc(input bit dv, input bit [PH-1:0] det, input bit rdy);
        ev.detect_valid = dv;
        ev.detect       = det;
        ev.event_ready  = rdy;
        @(posedge clock);
        #1;
        model_edge();
    endtask

    // Monitor: compares handshakes against the scoreboard
    always @(negedge clock) begin
        ent_t e;
        if (reset_n && run) begin
            chk("valid", int'(ev.event_valid), int'(m_valid));
            chk("overflow", int'(ev.overflow), int'(m_ovf));
            if (ev.event_valid && ev.event_ready) begin
                dut_pops++;
                last_time[0] = last_time[1];
                last_time[1] = int'(ev.event_time);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_empty actual_row=%0d actual_time=%0d expected=none",
                             ev.event_row, ev.event_time);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_row", int'(ev.event_row), e.row);
                    chk("event_time", int'(ev.event_time), e.tm);
                end
            end
        end
    end

    initial begin
        int          p0;
        int          t_r0;
        bit [31:0]   rnd;
        total = 0; bad = 0; dut_pops = 0; run = 1'b0;
        last_time[0] = 0; last_time[1] = 0;
        reset_n = 1'b0;
        ev.detect_valid = 1'b0;
        ev.detect       = '0;
        ev.event_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", int'(ev.event_valid), 0);
        chk("rst_row", int'(ev.event_row), 0);
        chk("rst_time", int'(ev.event_time), 0);
        chk("rst_overflow", int'(ev.overflow), 0);
        reset_n = 1'b1;
        model_reset();

        // Single rise sampled at timestamp 10
        while (m_ts != 10) cyc(1'b1, 5'b00000, 1'b1);
        p0 = dut_pops;
        repeat (9) cyc(1'b1, 5'b00100, 1'b1);
        chk("t1_pops", dut_pops - p0, 1);
        chk("t1_time", last_time[1], 10);

        // Three simultaneous rises drain lowest-row-first
        repeat (12) cyc(1'b1, 5'b00000, 1'b1);
        p0 = dut_pops;
        repeat (8) cyc(1'b1, 5'b10011, 1'b1);
        chk("t2_pops", dut_pops - p0, 3);

        // Hold-off swallows a quick re-toggle, later toggle reported
        repeat (12) cyc(1'b1, 5'b00000, 1'b1);
        p0 = dut_pops;
        cyc(1'b1, 5'b01000, 1'b1);
        cyc(1'b1, 5'b00000, 1'b1);
        cyc(1'b1, 5'b01000, 1'b1);
        repeat (10) cyc(1'b1, 5'b00000, 1'b1);
        repeat (7) cyc(1'b1, 5'b01000, 1'b1);
        chk("t3_pops", dut_pops - p0, 2);

        // Backpressure: FIFO fills, row 4 waits pending, then is re-hit
        repeat (12) cyc(1'b1, 5'b00000, 1'b1);
        p0 = dut_pops;
        t_r0 = m_ts;
        cyc(1'b1, 5'b00001, 1'b0);
        cyc(1'b1, 5'b00011, 1'b0);
        cyc(1'b1, 5'b00111, 1'b0);
        cyc(1'b1, 5'b01111, 1'b0);
        repeat (4) cyc(1'b1, 5'b11111, 1'b0);
        chk("t4_ovf_before", int'(ev.overflow), 0);
        cyc(1'b1, 5'b01111, 1'b0);
        cyc(1'b1, 5'b11111, 1'b0);
        chk("t4_ovf_after", int'(ev.overflow), 1);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 5'b11111, 1'b0);
            chk("t4_row_stable", int'(ev.event_row), 0);
            chk("t4_time_stable", int'(ev.event_time), t_r0);
        end
        repeat (12) cyc(1'b1, 5'b11111, 1'b1);
        chk("t4_pops", dut_pops - p0, 5);

        // Asynchronous reset in the middle of a stream
        repeat (12) cyc(1'b1, 5'b00000, 1'b1);
        repeat (5) cyc(1'b1, 5'b00011, 1'b0);
        chk("t5_valid_before", int'(ev.event_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", int'(ev.event_valid), 0);
        ev.detect      = '0;
        ev.event_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        chk("t5_ovf_cleared", int'(ev.overflow), 0);
        p0 = dut_pops;
        repeat (6) cyc(1'b1, 5'b00000, 1'b1);
        chk("t5_pops", dut_pops - p0, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            rnd = $urandom;
            cyc($urandom_range(0, 3) != 0, rnd[PH-1:0], $urandom_range(0, 3) != 0);
        end
        repeat (20) cyc(1'b1, 5'b00000, 1'b1);

        // Timestamp wrap
        while (m_ts != 16'hFFFF) cyc(1'b1, 5'b00000, 1'b1);
        cyc(1'b1, 5'b00001, 1'b1);
        while (m_ts != 3) cyc(1'b1, 5'b00000, 1'b1);
        repeat (9) cyc(1'b1, 5'b00010, 1'b1);
        chk("wrap_t0", last_time[0], 32'h0000FFFF);
        chk("wrap_t1", last_time[1], 3);

        chk("sb_empty", exp_q.size(), 0);
`ifdef EDGE_EVENT_STATS_EN
        chk("event_count", int'(ev.event_count), m_pops);
        chk("drop_count", int'(ev.drop_count), m_drops);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
